// File: rtl/sorter_input_buffer.sv
// Collects a stream of {dest, user, data} samples into a CHUNK_SIZE batch and
// presents it in parallel to the sorting network, padding short batches with max keys.
module sorter_input_buffer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned USER_WIDTH = 32,
    parameter int unsigned DEST_WIDTH = 32,
    parameter int unsigned CHUNK_SIZE = 8
) (
    input  logic                                           clock,
    input  logic                                           reset,
    input  logic [DATA_WIDTH-1:0]                          in_data,
    input  logic [USER_WIDTH-1:0]                          in_user,
    input  logic [DEST_WIDTH-1:0]                          in_dest,
    input  logic                                           in_valid,
    input  logic                                           in_last,
    output logic                                           in_ready,
    output logic [DATA_WIDTH+USER_WIDTH+DEST_WIDTH-1:0]    out_data [CHUNK_SIZE-1:0],
    output logic                                           out_valid,
    input  logic                                           out_ready,
    output logic [$clog2(CHUNK_SIZE+1)-1:0]                out_count,
    output logic                                           out_last
);

    localparam int unsigned ENTRY_W = DATA_WIDTH + USER_WIDTH + DEST_WIDTH;
    localparam int unsigned CNT_W   = $clog2(CHUNK_SIZE + 1);
    localparam logic [CNT_W-1:0]   LAST_IDX = CNT_W'(CHUNK_SIZE - 1);
    // Padding carries the largest key so it sorts above every real sample.
    localparam logic [ENTRY_W-1:0] PAD_ENTRY =
        {DEST_WIDTH'(0), USER_WIDTH'(0), {DATA_WIDTH{1'b1}}};

    typedef enum logic {
        FILL    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  idx;
    logic              closing_c;
    logic [ENTRY_W-1:0] beat_c;

    assign in_ready  = (state == FILL) && !reset;
    assign closing_c = (idx == LAST_IDX) || in_last;
    assign beat_c    = {in_dest, in_user, in_data};

    // Batch fill / present sequencer with registered batch outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= FILL;
            idx       <= '0;
            out_valid <= 1'b0;
            out_count <= '0;
            out_last  <= 1'b0;
            for (int unsigned i = 0; i < CHUNK_SIZE; i++) begin
                out_data[i] <= '0;
            end
        end else begin
            case (state)
                FILL: begin
                    if (in_valid) begin
                        for (int unsigned i = 0; i < CHUNK_SIZE; i++) begin
                            if (CNT_W'(i) == idx) begin
                                out_data[i] <= beat_c;
                            end else if (closing_c && (CNT_W'(i) > idx)) begin
                                out_data[i] <= PAD_ENTRY;
                            end
                        end
                        if (closing_c) begin
                            out_count <= idx + CNT_W'(1);
                            out_last  <= in_last;
                            out_valid <= 1'b1;
                            state     <= PRESENT;
                        end else begin
                            idx <= idx + CNT_W'(1);
                        end
                    end
                end
                PRESENT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        idx       <= '0;
                        state     <= FILL;
                    end
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sorter_input_buffer.sv
// Self-checking bench for sorter_input_buffer: directed scenarios plus randomized
// batches compared against a queue-based batch model.
module tb_sorter_input_buffer;

    localparam int DW = 32;
    localparam int UW = 32;
    localparam int DSW = 32;
    localparam int CH = 8;
    localparam int EW = DW + UW + DSW;
    localparam int CW = $clog2(CH + 1);

    logic           clock;
    logic           reset;
    logic [DW-1:0]  in_data;
    logic [UW-1:0]  in_user;
    logic [DSW-1:0] in_dest;
    logic           in_valid;
    logic           in_last;
    logic           in_ready;
    logic [EW-1:0]  out_data [CH-1:0];
    logic           out_valid;
    logic           out_ready;
    logic [CW-1:0]  out_count;
    logic           out_last;

    int checks = 0;
    int errors = 0;

    // Reference model state: pending beats and the last completed batch.
    logic [EW-1:0] pend [$];
    logic [EW-1:0] exp_data [CH];
    int            exp_count;
    bit            exp_last;
    bit            exp_done;
    logic [EW-1:0] pad_entry;

    sorter_input_buffer #(
        .DATA_WIDTH(DW), .USER_WIDTH(UW), .DEST_WIDTH(DSW), .CHUNK_SIZE(CH)
    ) dut (
        .clock(clock), .reset(reset),
        .in_data(in_data), .in_user(in_user), .in_dest(in_dest),
        .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_count(out_count), .out_last(out_last)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic model_clear();
        pend.delete();
        exp_done = 1'b0;
    endtask

    task automatic model_beat(input logic [EW-1:0] e, input bit last);
        pend.push_back(e);
        if (pend.size() == CH || last) begin
            for (int i = 0; i < CH; i++) exp_data[i] = (i < pend.size()) ? pend[i] : pad_entry;
            exp_count = pend.size();
            exp_last  = last;
            exp_done  = 1'b1;
            pend.delete();
        end
    endtask

    // Drives one beat starting at a falling edge; returns at the next falling edge.
    task automatic drive_beat(input logic [DW-1:0] d, input logic [UW-1:0] u,
                              input logic [DSW-1:0] de, input bit last);
        in_data = d; in_user = u; in_dest = de; in_last = last; in_valid = 1'b1;
        @(negedge clock);
        in_valid = 1'b0; in_last = 1'b0;
        model_beat({de, u, d}, last);
    endtask

    task automatic release_batch();
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        exp_done = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        reset = 1'b0;
        model_clear();
        @(negedge clock);
        checks++;
        if (out_valid !== 1'b0 || out_count !== CW'(0) || out_last !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: valid=%b count=%0d last=%b ready=%b expected 0 0 0 1",
                     out_valid, out_count, out_last, in_ready);
        end
        for (int i = 0; i < CH; i++) begin
            checks++;
            if (out_data[i] !== '0) begin errors++; $display("FAIL reset_data[%0d]: got %h expected 0", i, out_data[i]); end
        end
    endtask

    task automatic test_full_batch();
        int keys [CH] = '{7, 3, 9, 1, 0, 5, 2, 8};
        for (int i = 0; i < CH; i++) begin
            drive_beat(DW'(keys[i]), UW'(i + 100), DSW'(i + 200), 1'b0);
            if (i == CH - 2) begin
                checks++;
                if (out_valid !== 1'b0) begin errors++; $display("FAIL full_early_valid: got %b expected 0", out_valid); end
            end
        end
        checks++;
        if (out_valid !== 1'b1 || out_count !== CW'(8) || out_last !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_ctrl: valid=%b count=%0d last=%b ready=%b expected 1 8 0 0",
                     out_valid, out_count, out_last, in_ready);
        end
        for (int i = 0; i < CH; i++) begin
            checks++;
            if (out_data[i][DW-1:0] !== DW'(keys[i]) || out_data[i] !== exp_data[i]) begin
                errors++; $display("FAIL full_data[%0d]: got %h expected %h", i, out_data[i], exp_data[i]);
            end
        end
        release_batch();
    endtask

    task automatic test_partial();
        drive_beat(32'd4, 32'h11, 32'h21, 1'b0);
        drive_beat(32'd6, 32'h12, 32'h22, 1'b0);
        drive_beat(32'd2, 32'h13, 32'h23, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_count !== CW'(3) || out_last !== 1'b1) begin
            errors++; $display("FAIL partial_ctrl: valid=%b count=%0d last=%b expected 1 3 1", out_valid, out_count, out_last);
        end
        for (int i = 0; i < CH; i++) begin
            checks++;
            if (out_data[i] !== exp_data[i] || (i >= 3 && out_data[i] !== {64'h0, 32'hFFFF_FFFF})) begin
                errors++; $display("FAIL partial_data[%0d]: got %h expected %h", i, out_data[i], exp_data[i]);
            end
        end
        release_batch();
    endtask

    task automatic test_single();
        drive_beat(32'h10, 32'hA, 32'h5, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_count !== CW'(1) || out_last !== 1'b1 || out_data[0] !== {32'h5, 32'hA, 32'h10}) begin
            errors++; $display("FAIL single: valid=%b count=%0d last=%b d0=%h expected 1 1 1 %h",
                               out_valid, out_count, out_last, out_data[0], {32'h5, 32'hA, 32'h10});
        end
        for (int i = 1; i < CH; i++) begin
            checks++;
            if (out_data[i] !== pad_entry) begin errors++; $display("FAIL single_pad[%0d]: got %h expected %h", i, out_data[i], pad_entry); end
        end
        release_batch();
    endtask

    task automatic test_backpressure();
        int bad = 0;
        drive_beat(32'h55, 32'h1, 32'h2, 1'b0);
        drive_beat(32'h66, 32'h3, 32'h4, 1'b1);
        for (int c = 0; c < 20; c++) begin
            in_valid = 1'b1; in_last = $urandom_range(0, 1);
            in_data = $urandom; in_user = $urandom; in_dest = $urandom;
            @(negedge clock);
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_count !== CW'(2) || out_last !== 1'b1) bad++;
            for (int i = 0; i < CH; i++) if (out_data[i] !== exp_data[i]) bad++;
        end
        in_valid = 1'b0; in_last = 1'b0;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL backpressure_hold: got %0d unstable samples expected 0", bad); end
        release_batch();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL backpressure_release: valid=%b ready=%b expected 0 1", out_valid, in_ready);
        end
        drive_beat(32'h77, 32'h8, 32'h9, 1'b1);
        checks++;
        if (out_count !== CW'(1) || out_data[0] !== exp_data[0]) begin
            errors++; $display("FAIL backpressure_slot0: count=%0d d0=%h expected 1 %h", out_count, out_data[0], exp_data[0]);
        end
        release_batch();
    endtask

    task automatic test_last_coincident();
        for (int i = 0; i < CH; i++) drive_beat($urandom, $urandom, $urandom, i == CH - 1);
        checks++;
        if (out_valid !== 1'b1 || out_count !== CW'(8) || out_last !== 1'b1) begin
            errors++; $display("FAIL coincident_ctrl: valid=%b count=%0d last=%b expected 1 8 1", out_valid, out_count, out_last);
        end
        release_batch();
        repeat (3) @(negedge clock);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL coincident_extra: valid=%b ready=%b expected 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < ((pass == 0) ? 5 : CH); i++) drive_beat($urandom, $urandom, $urandom, 1'b0);
            reset = 1'b1;
            @(negedge clock);
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_count !== CW'(0)) begin
                errors++; $display("FAIL reset_mid%0d: ready=%b valid=%b count=%0d expected 0 0 0", pass, in_ready, out_valid, out_count);
            end
            reset = 1'b0;
            model_clear();
            for (int i = 0; i < CH; i++) drive_beat($urandom, $urandom, $urandom, 1'b0);
            checks++;
            if (out_valid !== 1'b1 || out_count !== CW'(8) || out_last !== 1'b0) begin
                errors++; $display("FAIL reset_mid%0d_ctrl: valid=%b count=%0d last=%b expected 1 8 0", pass, out_valid, out_count, out_last);
            end
            for (int i = 0; i < CH; i++) begin
                checks++;
                if (out_data[i] !== exp_data[i]) begin errors++; $display("FAIL reset_mid%0d_data[%0d]: got %h expected %h", pass, i, out_data[i], exp_data[i]); end
            end
            if (pass == 0) release_batch();
        end
        release_batch();
    endtask

    task automatic test_random();
        for (int b = 0; b < 40; b++) begin
            int guard = 0;
            while (!exp_done && guard < 4 * CH) begin
                guard++;
                if ($urandom_range(0, 3) == 0) begin
                    in_last = $urandom_range(0, 1);
                    in_data = $urandom;
                    @(negedge clock);
                    in_last = 1'b0;
                end
                drive_beat($urandom, $urandom, $urandom, $urandom_range(0, 5) == 0);
            end
            checks++;
            if (out_valid !== 1'b1 || out_count !== CW'(exp_count) || out_last !== exp_last) begin
                errors++; $display("FAIL random%0d_ctrl: valid=%b count=%0d last=%b expected 1 %0d %b",
                                   b, out_valid, out_count, out_last, exp_count, exp_last);
            end
            for (int i = 0; i < CH; i++) begin
                checks++;
                if (out_data[i] !== exp_data[i]) begin errors++; $display("FAIL random%0d_data[%0d]: got %h expected %h", b, i, out_data[i], exp_data[i]); end
            end
            repeat ($urandom_range(0, 3)) @(negedge clock);
            release_batch();
        end
    endtask

    initial begin
        pad_entry = {64'h0, 32'hFFFF_FFFF};
        reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        in_data = '0; in_user = '0; in_dest = '0;
        model_clear();
        @(negedge clock);
        test_reset();
        test_full_batch();
        test_partial();
        test_single();
        test_backpressure();
        test_last_coincident();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
